// File: rtl/pll_reconfig_ctrl_if.sv
// Handshake bundle between the PLL reconfiguration controller and its UART,
// PLL reconfig port and millisecond-counter neighbours.
interface pll_reconfig_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_write;
  logic       cfg_waitrequest;
  logic       pll_locked;
  logic       reconfig_en;
  logic       busy;
  logic [1:0] cur_profile;

  modport master (
    input  rx_data, rx_valid, tx_ready, cfg_waitrequest, pll_locked,
    output tx_data, tx_valid, cfg_addr, cfg_data, cfg_write,
           reconfig_en, busy, cur_profile
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, cfg_waitrequest, pll_locked,
    input  tx_data, tx_valid, cfg_addr, cfg_data, cfg_write,
           reconfig_en, busy, cur_profile
  );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// Sequences a UART-requested PLL divider reconfiguration: freeze counter,
// write M/C/start, wait for lock with timeout, release and report status.
module pll_reconfig_ctrl #(
  parameter int LOCK_TIMEOUT  = 50_000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 resett,
  pll_reconfig_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_HOLD, S_WR_M, S_WR_C, S_WR_START,
    S_SETTLE, S_WAIT_LOCK, S_RELEASE, S_REPORT
  } state_t;

  localparam logic [15:0] TO_LAST     = 16'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  // Divider profile table, packed as {M, C}.
  function automatic logic [15:0] profile_mc(input logic [1:0] p);
    logic [15:0] mc;
    case (p)
      2'd0:    mc = {8'd12, 8'd12};
      2'd1:    mc = {8'd16, 8'd8};
      2'd2:    mc = {8'd20, 8'd10};
      2'd3:    mc = {8'd24, 8'd6};
      default: mc = {8'd12, 8'd12};
    endcase
    return mc;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  profile_q, profile_d;
  logic [1:0]  cur_profile_q, cur_profile_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [1:0]  cfg_addr_q, cfg_addr_d;
  logic [7:0]  cfg_data_q, cfg_data_d;
  logic        cfg_write_q, cfg_write_d;
  logic        reconfig_en_q, reconfig_en_d;
  logic        busy_q, busy_d;
  logic        cmd_ok_s;
  logic [15:0] mc_s;

  assign cmd_ok_s = (bus.rx_data[7:4] == 4'hA) && (bus.rx_data[3:2] == 2'b00);
  assign mc_s     = profile_mc(profile_q);

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    profile_d     = profile_q;
    cur_profile_d = cur_profile_q;
    settle_cnt_d  = settle_cnt_q;
    to_cnt_d      = to_cnt_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    cfg_addr_d    = cfg_addr_q;
    cfg_data_d    = cfg_data_q;
    cfg_write_d   = cfg_write_q;
    // busy and reconfig_en follow the state one cycle late, so the counter
    // is still frozen during RELEASE and drops as REPORT begins.
    busy_d        = (state_q != S_IDLE);
    reconfig_en_d = (state_q != S_IDLE) && (state_q != S_REPORT);

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && cmd_ok_s) begin
          profile_d = bus.rx_data[1:0];
          state_d   = S_HOLD;
        end else if (bus.rx_valid) begin
          tx_data_d = 8'h15;
          state_d   = S_REPORT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        state_d = S_WR_M;
      end
      S_WR_M: begin
        // First cycle loads the M write; later writes load on the accepting edge.
        if (!cfg_write_q) begin
          cfg_write_d = 1'b1;
          cfg_addr_d  = 2'd0;
          cfg_data_d  = mc_s[15:8];
        end else if (!bus.cfg_waitrequest) begin
          cfg_addr_d = 2'd1;
          cfg_data_d = mc_s[7:0];
          state_d    = S_WR_C;
        end else begin
          state_d = S_WR_M;
        end
      end
      S_WR_C: begin
        if (!bus.cfg_waitrequest) begin
          cfg_addr_d = 2'd2;
          cfg_data_d = 8'h01;
          state_d    = S_WR_START;
        end else begin
          state_d = S_WR_C;
        end
      end
      S_WR_START: begin
        if (!bus.cfg_waitrequest) begin
          cfg_write_d  = 1'b0;
          settle_cnt_d = 8'd0;
          to_cnt_d     = 16'd0;
          state_d      = S_SETTLE;
        end else begin
          state_d = S_WR_START;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_WAIT_LOCK;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      S_WAIT_LOCK: begin
        if (bus.pll_locked) begin
          cur_profile_d = profile_q;
          tx_data_d     = 8'h30 + {6'd0, profile_q};
          state_d       = S_RELEASE;
        end else if (to_cnt_q == TO_LAST) begin
          tx_data_d = 8'h54;
          state_d   = S_RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_RELEASE: begin
        state_d = S_REPORT;
      end
      S_REPORT: begin
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge resett) begin
    if (resett) begin
      state_q       <= S_IDLE;
      profile_q     <= 2'd0;
      cur_profile_q <= 2'd0;
      settle_cnt_q  <= 8'd0;
      to_cnt_q      <= 16'd0;
      tx_data_q     <= 8'd0;
      tx_valid_q    <= 1'b0;
      cfg_addr_q    <= 2'd0;
      cfg_data_q    <= 8'd0;
      cfg_write_q   <= 1'b0;
      reconfig_en_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      profile_q     <= profile_d;
      cur_profile_q <= cur_profile_d;
      settle_cnt_q  <= settle_cnt_d;
      to_cnt_q      <= to_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      cfg_addr_q    <= cfg_addr_d;
      cfg_data_q    <= cfg_data_d;
      cfg_write_q   <= cfg_write_d;
      reconfig_en_q <= reconfig_en_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.cfg_addr    = cfg_addr_q;
  assign bus.cfg_data    = cfg_data_q;
  assign bus.cfg_write   = cfg_write_q;
  assign bus.reconfig_en = reconfig_en_q;
  assign bus.busy        = busy_q;
  assign bus.cur_profile = cur_profile_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Randomized bench for pll_reconfig_ctrl against a transaction-level model
// built from the profile table and the cycle offsets of the sequence.
module tb_pll_reconfig_ctrl;
  localparam int LT     = 100;
  localparam int SETTLE = 4;

  logic clk;
  logic resett;
  int   n_checks;
  int   n_errors;
  logic [1:0] exp_cur;
  int   m_tab [4] = '{12, 16, 20, 24};
  int   c_tab [4] = '{12, 8, 10, 6};

  pll_reconfig_ctrl_if bus ();

  pll_reconfig_ctrl #(.LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SETTLE)) dut (
    .clk    (clk),
    .resett (resett),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Occasionally offer a byte that must be ignored while the controller is busy.
  task automatic junk();
    bus.rx_valid = ($urandom_range(0, 3) == 0);
    bus.rx_data  = 8'hA0 | 8'($urandom_range(0, 3));
  endtask

  function automatic logic [23:0] all_outs();
    return {bus.reconfig_en, bus.cfg_write, bus.tx_valid, bus.busy,
            bus.tx_data, bus.cfg_addr, bus.cfg_data, bus.cur_profile};
  endfunction

  // One command from the idle state through to the report handshake.
  task automatic do_cmd(input logic [7:0] cmd, input int stall_lo, input int stall_hi,
                        input int lock_d, input int rdy_wait);
    bit         ok;
    bit         lock_ok;
    int         l_off;
    int         s;
    logic [1:0] p;
    logic [7:0] exp_tx;
    logic [1:0] wa [3];
    logic [7:0] wd [3];
    ok = (cmd[7:4] == 4'hA) && (cmd[3:2] == 2'b00);
    p  = cmd[1:0];
    wa[0] = 2'd0; wd[0] = 8'(m_tab[p]);
    wa[1] = 2'd1; wd[1] = 8'(c_tab[p]);
    wa[2] = 2'd2; wd[2] = 8'h01;

    bus.rx_data  = cmd;
    bus.rx_valid = 1'b1;
    tick();                                   // edge N
    bus.rx_valid = 1'b0;
    check_eq("at_n", 32'({bus.busy, bus.reconfig_en, bus.tx_valid}), 32'(3'b000));
    tick();                                   // edge N+1
    if (!ok) begin
      exp_tx = 8'h15;
      check_eq("nak_n1", 32'({bus.tx_valid, bus.tx_data, bus.reconfig_en, bus.busy, bus.cfg_write}),
               32'({1'b1, 8'h15, 1'b0, 1'b1, 1'b0}));
    end else begin
      check_eq("hold_n1", 32'({bus.reconfig_en, bus.busy, bus.cfg_write}), 32'(3'b110));
      tick();                                 // edge N+2: first write visible
      for (int k = 0; k < 3; k++) begin
        s = int'($urandom_range(stall_hi, stall_lo));
        bus.cfg_waitrequest = 1'b1;
        for (int j = 0; j < s; j++) begin
          check_eq("wr_stall", 32'({bus.cfg_write, bus.cfg_addr, bus.cfg_data}), 32'({1'b1, wa[k], wd[k]}));
          junk();
          tick();
        end
        bus.cfg_waitrequest = 1'b0;
        check_eq("wr", 32'({bus.cfg_write, bus.cfg_addr, bus.cfg_data}), 32'({1'b1, wa[k], wd[k]}));
        junk();
        tick();
      end
      // WAIT_LOCK starts SETTLE edges after the start write; lock at offset d is
      // sampled one edge later, timeout after exactly LT cycles in WAIT_LOCK.
      lock_ok = (lock_d < LT);
      l_off   = lock_ok ? (SETTLE + 1 + lock_d) : (SETTLE + LT);
      for (int t = 0; t < l_off; t++) begin
        if (lock_ok && t == SETTLE + lock_d) bus.pll_locked = 1'b1;
        check_eq("run", 32'({bus.cfg_write, bus.reconfig_en, bus.tx_valid, bus.busy}), 32'(4'b0101));
        junk();
        tick();
      end
      bus.rx_valid = 1'b0;
      check_eq("at_l", 32'({bus.reconfig_en, bus.tx_valid}), 32'(2'b10));
      tick();
      check_eq("at_l1", 32'({bus.reconfig_en, bus.tx_valid}), 32'(2'b10));
      tick();                                 // edge L+2
      if (lock_ok) begin
        exp_tx  = 8'h30 + {6'd0, p};
        exp_cur = p;
      end else begin
        exp_tx = 8'h54;
      end
    end

    for (int r = 0; r < rdy_wait; r++) begin
      check_eq("rpt_wait", 32'({bus.tx_valid, bus.tx_data, bus.cfg_write, bus.reconfig_en, bus.cur_profile}),
               32'({1'b1, exp_tx, 1'b0, 1'b0, exp_cur}));
      junk();
      tick();
    end
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    check_eq("rpt", 32'({bus.tx_valid, bus.tx_data, bus.cur_profile}), 32'({1'b1, exp_tx, exp_cur}));
    tick();                                   // handshake edge
    bus.tx_ready   = 1'b0;
    bus.pll_locked = 1'b0;
    check_eq("post_hs", 32'({bus.tx_valid, bus.busy}), 32'(2'b01));
    tick();
    check_eq("idle", 32'({bus.busy, bus.reconfig_en, bus.tx_valid, bus.cur_profile}),
             32'({3'b000, exp_cur}));
  endtask

  initial begin
    logic [7:0] cmd;
    int         ld;
    n_checks = 0;
    n_errors = 0;
    exp_cur  = 2'd0;
    resett   = 1'b1;
    bus.rx_data = 8'd0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    bus.cfg_waitrequest = 1'b0; bus.pll_locked = 1'b0;
    tick();
    tick();
    check_eq("reset", 32'(all_outs()), 32'd0);
    @(negedge clk);
    resett = 1'b0;
    tick();

    do_cmd(8'hA1, 0, 0, 5, 0);                // consecutive writes, lock 5 in
    do_cmd(8'hA2, 3, 3, 2, 1);                // each write stalled 3 cycles
    do_cmd(8'hA3, 0, 0, LT + 5, 0);           // timeout, profile 2 kept
    do_cmd(8'h41, 0, 0, 0, 0);                // NAK: wrong opcode
    do_cmd(8'hA5, 0, 0, 0, 0);                // NAK: reserved bits set
    do_cmd(8'hA0, 1, 2, 0, 10);               // lock immediately, 10-cycle backpressure
    do_cmd(8'hA3, 0, 1, LT - 1, 2);           // lock on the timeout cycle wins

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) != 0) cmd = {4'hA, 2'b00, 2'($urandom_range(0, 3))};
      else cmd = 8'($urandom);
      ld = ($urandom_range(0, 4) == 0) ? LT + int'($urandom_range(0, 10)) : int'($urandom_range(0, LT - 1));
      do_cmd(cmd, 0, int'($urandom_range(0, 3)), ld, int'($urandom_range(0, 5)));
    end

    // Reset during SETTLE aborts with no report.
    bus.rx_data  = 8'hA1;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_eq("pre_abort", 32'({bus.reconfig_en, bus.cfg_write, bus.busy}), 32'(3'b101));
    #2;
    resett = 1'b1;
    #1;
    exp_cur = 2'd0;
    check_eq("abort", 32'(all_outs()), 32'd0);
    @(negedge clk);
    resett = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("after_abort", 32'({bus.tx_valid, bus.cfg_write, bus.reconfig_en, bus.busy}), 32'd0);
    end
    do_cmd(8'hA2, 0, 1, 3, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
